rca_seq_ctrl: RTL and testbench



---
 rtl/rca_seq_ctrl.sv | 109 ++++++++++
 tb/tb_rca_seq_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: WORDS*4-bit add/subtract computed one nibble per clock through one shared 4-bit ripple slice.
// Define RCA_SEQ_OVF_EN to add the registered two's-complement overflow output ovf.
module rca_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WORDS-1:0] a,
  input  logic [4*WORDS-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] sum,
  output logic               cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int N  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_r, b_r, acc, acc_nxt;
  logic          sub_r, carry;
  logic [IW-1:0] idx;
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    slice;
  logic          accept, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (idx == LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Shared slice; acc_nxt includes the current nibble so the final result can be published on the same edge.
  always_comb begin
    a_nib   = a_r[idx*4 +: 4];
    b_nib   = sub_r ? ~b_r[idx*4 +: 4] : b_r[idx*4 +: 4];
    slice   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    acc_nxt = acc;
    acc_nxt[idx*4 +: 4] = slice[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        sub_r <= sub;
        carry <= sub | cin;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        carry <= slice[4];
        idx   <= idx + IW'(1);
        if (last) begin
          sum  <= acc_nxt;
          cout <= slice[4];
          done <= 1'b1;
`ifdef RCA_SEQ_OVF_EN
          // Carry into the MSB bit is recovered from the MSB sum bit and its two operand bits.
          ovf  <= (a_nib[3] ^ b_nib[3] ^ slice[3]) ^ slice[4];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl (WORDS=4): table-driven vectors plus hand sequences for back-to-back and reset cases.
// Define RCA_SEQ_OVF_EN to also check the ovf output.
module tb_rca_seq_ctrl;

  localparam int WORDS = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
    string       name;
  } vec_t;

  logic        clk, rst_n, start, cin, sub;
  logic [15:0] a, b, sum;
  logic        busy, done, cout;
`ifdef RCA_SEQ_OVF_EN
  logic        ovf;
`endif

  int checks, passes;
  logic [15:0] exp_hold;
  vec_t vecs[12];

  rca_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op, scramble inputs after acceptance, check sum holds while busy, then check result and latency.
  task automatic applyStimulus(input vec_t v);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
    checkOutput({v.name, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      checkOutput({v.name, "_hold"}, 32'(sum), 32'(exp_hold));
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({v.name, "_latency"}, 32'(lat), 32'(WORDS));
    checkOutput({v.name, "_sum"}, 32'(sum), 32'(v.s));
    checkOutput({v.name, "_cout"}, 32'(cout), 32'(v.co));
    checkOutput({v.name, "_idlebusy"}, 32'(busy), 32'd0);
`ifdef RCA_SEQ_OVF_EN
    checkOutput({v.name, "_ovf"}, 32'(ovf), 32'(v.ov));
`endif
    exp_hold = v.s;
    @(posedge clk); #1;
    checkOutput({v.name, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic"};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, "add_wrap_cin"};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
    vecs[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow"};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "add_zero"};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_negovf"};
    vecs[7]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal"};
    vecs[8]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, "sub_cin_ignored"};
    vecs[9]  = '{16'h89AB, 16'h7654, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple_all"};
    vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_posovf"};
    vecs[11] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};

    checks = 0; passes = 0; exp_hold = 16'h0000;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
`ifdef RCA_SEQ_OVF_EN
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // start held high: accepts every WORDS+1 cycles, operands changed mid-RUN must not leak in.
    $display("[TB] back-to-back with start held");
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b_busy0", 32'(busy), 32'd1);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin a = 16'h1000; b = 16'h2000; end
      if (e == 6) begin a = 16'h0100; b = 16'h0200; end
      checkOutput($sformatf("b2b_done_e%0d", e), 32'(done), 32'(e == 4 || e == 9));
      checkOutput($sformatf("b2b_busy_e%0d", e), 32'(busy), 32'(!(e == 4 || e == 9)));
      if (e == 4) checkOutput("b2b_sum1", 32'(sum), 32'h0003);
      if (e == 9) checkOutput("b2b_sum2", 32'(sum), 32'h3000);
    end
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_latency3", 32'(lat), 32'(WORDS));
    checkOutput("b2b_sum3", 32'(sum), 32'h0300);
    checkOutput("b2b_cout3", 32'(cout), 32'd0);
    exp_hold = 16'h0300;

    // Asynchronous reset two RUN cycles into an op: outputs clear at once and no done follows.
    $display("[TB] reset mid-run");
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_hold = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst_nodone_%0d", i), 32'(done), 32'd0);
    end
    applyStimulus(vecs[0]);
    applyStimulus(vecs[4]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
